// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSRs, mcycle/minstret, Zicsr execute with registered
// write-back, and the trap-entry / mret sequencer that redirects fetch.
//
// state | meaning
// IDLE  | accepting EX instructions
// TRAP  | latching mcause/mtval, stacking MIE into MPIE
// REDIR | redirecting fetch to the trap handler
// MRET  | restoring MIE from MPIE, redirecting fetch to mepc
module csr_trap_unit #(
  parameter int              XLEN        = 64,
  parameter int              NUM_LCL_IRQ = 4,
  parameter logic [XLEN-1:0] MTVEC_RST   = '0,
  parameter bit              VECTORED_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   instr_vld_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [5:0]             csr_op_i,
  input  logic [11:0]            csr_addr_i,
  input  logic [4:0]             rs1_idx_i,
  input  logic [XLEN-1:0]        data_rs1_i,
  input  logic [4:0]             csr_imm_i,
  input  logic [4:0]             addr_reg_wr_i,
  input  logic                   exp_vld_i,
  input  logic [3:0]             exp_cause_i,
  input  logic [XLEN-1:0]        exp_tval_i,
  input  logic                   mret_i,
  input  logic                   retire_i,
  input  logic                   ext_irq_i,
  input  logic                   sft_irq_i,
  input  logic                   tmr_irq_i,
  input  logic [NUM_LCL_IRQ-1:0] lcl_irq_i,
  output logic                   wb_wen_o,
  output logic [4:0]             wb_addr_o,
  output logic [XLEN-1:0]        wb_data_o,
  output logic                   redirect_o,
  output logic [XLEN-1:0]        redirect_pc_o,
  output logic                   busy_o,
  output logic                   glb_irq_o
);
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;

  function automatic logic [XLEN-1:0] irq_mask_f();
    logic [XLEN-1:0] m;
    m     = '0;
    m[3]  = 1'b1;
    m[7]  = 1'b1;
    m[11] = 1'b1;
    for (int i = 0; i < NUM_LCL_IRQ; i++) m[16+i] = 1'b1;
    return m;
  endfunction
  localparam logic [XLEN-1:0] IRQ_MASK = irq_mask_f();

  typedef enum logic [1:0] {S_IDLE, S_TRAP, S_REDIR, S_MRET} state_t;
  state_t state_q, state_d;

  logic            mstatus_mie_q, mstatus_mpie_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] mcycle_q, minstret_q;
  logic            trap_intr_q;
  logic [4:0]      trap_code_q;
  logic [XLEN-1:0] trap_tval_q;
  logic            wb_wen_q;
  logic [4:0]      wb_addr_q;
  logic [XLEN-1:0] wb_data_q;

  logic [XLEN-1:0] mip, irq_pend, csr_src, csr_rdata, csr_wdata, vec_base;
  logic            is_csr, op_s, op_c, op_imm, wr_req, addr_ok, csr_illegal;
  logic            fire, exc, irq_hit, take_trap, take_mret, do_csr, csr_we;
  logic [4:0]      irq_code;

  assign is_csr  = |csr_op_i;
  assign op_s    = csr_op_i[1] | csr_op_i[4];
  assign op_c    = csr_op_i[2] | csr_op_i[5];
  assign op_imm  = |csr_op_i[5:3];
  assign csr_src = op_imm ? {{(XLEN-5){1'b0}}, csr_imm_i} : data_rs1_i;
  // set/clear with a zero source is a pure read
  assign wr_req  = csr_op_i[0] | csr_op_i[3] |
                   ((op_s | op_c) & (op_imm ? (csr_imm_i != 5'd0) : (rs1_idx_i != 5'd0)));

  always_comb begin
    mip     = '0;
    mip[3]  = sft_irq_i;
    mip[7]  = tmr_irq_i;
    mip[11] = ext_irq_i;
    for (int i = 0; i < NUM_LCL_IRQ; i++) mip[16+i] = lcl_irq_i[i];
  end

  // later assignments override earlier ones, so the highest priority source is last
  always_comb begin
    irq_pend = mip & mie_q;
    irq_hit  = mstatus_mie_q & (|irq_pend);
    irq_code = 5'd0;
    for (int i = NUM_LCL_IRQ-1; i >= 0; i--)
      if (irq_pend[16+i]) irq_code = 5'(16+i);
    if (irq_pend[7])  irq_code = 5'd7;
    if (irq_pend[3])  irq_code = 5'd3;
    if (irq_pend[11]) irq_code = 5'd11;
  end

  always_comb begin
    addr_ok   = 1'b1;
    csr_rdata = '0;
    case (csr_addr_i)
      A_MSTATUS: begin
        csr_rdata[3] = mstatus_mie_q;
        csr_rdata[7] = mstatus_mpie_q;
      end
      A_MIE:      csr_rdata = mie_q;
      A_MTVEC:    csr_rdata = mtvec_q;
      A_MSCRATCH: csr_rdata = mscratch_q;
      A_MEPC:     csr_rdata = mepc_q;
      A_MCAUSE:   csr_rdata = mcause_q;
      A_MTVAL:    csr_rdata = mtval_q;
      A_MIP:      csr_rdata = mip;
      A_MCYCLE:   csr_rdata = mcycle_q;
      A_MINSTRET: csr_rdata = minstret_q;
      default:    addr_ok   = 1'b0;
    endcase
  end

  always_comb begin
    csr_wdata = csr_src;
    if (op_s)      csr_wdata = csr_rdata | csr_src;
    else if (op_c) csr_wdata = csr_rdata & ~csr_src;
  end

  assign fire        = (state_q == S_IDLE) & instr_vld_i;
  assign csr_illegal = is_csr & (~addr_ok | (wr_req & (csr_addr_i[11:10] == 2'b11)));
  assign exc         = exp_vld_i | csr_illegal;
  assign take_trap   = fire & (exc | irq_hit);
  assign take_mret   = fire & ~take_trap & mret_i;
  assign do_csr      = fire & ~take_trap & ~mret_i & is_csr;
  assign csr_we      = do_csr & wr_req;
  assign vec_base    = {mtvec_q[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take_trap)      state_d = S_TRAP;
        else if (take_mret) state_d = S_MRET;
      end
      S_TRAP:  state_d = S_REDIR;
      S_REDIR: state_d = S_IDLE;
      S_MRET:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state_q != S_IDLE);
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    case (state_q)
      S_REDIR: begin
        redirect_o    = 1'b1;
        redirect_pc_o = (mtvec_q[0] & trap_intr_q) ?
                        vec_base + {{(XLEN-7){1'b0}}, trap_code_q, 2'b00} : vec_base;
      end
      S_MRET: begin
        redirect_o    = 1'b1;
        redirect_pc_o = mepc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RST;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
      trap_intr_q    <= 1'b0;
      trap_code_q    <= '0;
      trap_tval_q    <= '0;
      wb_wen_q       <= 1'b0;
      wb_addr_q      <= '0;
      wb_data_q      <= '0;
    end else begin
      mcycle_q <= mcycle_q + XLEN'(1);
      if (retire_i) minstret_q <= minstret_q + XLEN'(1);
      wb_wen_q  <= do_csr & (addr_reg_wr_i != 5'd0);
      wb_addr_q <= do_csr ? addr_reg_wr_i : 5'd0;
      wb_data_q <= do_csr ? csr_rdata : '0;
      if (take_trap) begin
        mepc_q      <= {pc_i[XLEN-1:2], 2'b00};
        trap_intr_q <= ~exc;
        trap_code_q <= exc ? (exp_vld_i ? {1'b0, exp_cause_i} : 5'd2) : irq_code;
        trap_tval_q <= exp_vld_i ? exp_tval_i : '0;
      end
      // a CSR write to a counter lands after the increment above and wins
      if (csr_we) begin
        case (csr_addr_i)
          A_MSTATUS: begin
            mstatus_mie_q  <= csr_wdata[3];
            mstatus_mpie_q <= csr_wdata[7];
          end
          A_MIE:      mie_q      <= csr_wdata & IRQ_MASK;
          A_MTVEC:    mtvec_q    <= {csr_wdata[XLEN-1:2], 1'b0, csr_wdata[0] & VECTORED_EN};
          A_MSCRATCH: mscratch_q <= csr_wdata;
          A_MEPC:     mepc_q     <= {csr_wdata[XLEN-1:2], 2'b00};
          A_MCAUSE:   mcause_q   <= csr_wdata;
          A_MTVAL:    mtval_q    <= csr_wdata;
          A_MCYCLE:   mcycle_q   <= csr_wdata;
          A_MINSTRET: minstret_q <= csr_wdata;
          default: ;
        endcase
      end
      if (state_q == S_TRAP) begin
        mcause_q       <= {trap_intr_q, {(XLEN-6){1'b0}}, trap_code_q};
        mtval_q        <= trap_tval_q;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end
      if (state_q == S_MRET) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end
    end
  end

  assign wb_wen_o  = wb_wen_q;
  assign wb_addr_o = wb_addr_q;
  assign wb_data_o = wb_data_q;
  assign glb_irq_o = mstatus_mie_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: directed scenarios plus random instruction stream,
// compared against a transaction-level model of the machine-mode CSR state.
module tb_csr_trap_unit;
  localparam int NL = 4;
  localparam logic [5:0] OP_RW = 6'b000001, OP_RS = 6'b000010, OP_RC = 6'b000100;
  localparam logic [5:0] OP_RWI = 6'b001000, OP_RSI = 6'b010000, OP_RCI = 6'b100000;

  logic clk = 1'b0, rst_n = 1'b1;
  logic instr_vld_i = 0, exp_vld_i = 0, mret_i = 0, retire_i = 0;
  logic ext_irq_i = 0, sft_irq_i = 0, tmr_irq_i = 0;
  logic [NL-1:0] lcl_irq_i = '0;
  logic [63:0] pc_i = '0, data_rs1_i = '0, exp_tval_i = '0;
  logic [5:0] csr_op_i = '0;
  logic [11:0] csr_addr_i = '0;
  logic [4:0] rs1_idx_i = '0, csr_imm_i = '0, addr_reg_wr_i = '0;
  logic [3:0] exp_cause_i = '0;
  logic wb_wen_o, redirect_o, busy_o, glb_irq_o;
  logic [4:0] wb_addr_o;
  logic [63:0] wb_data_o, redirect_pc_o;

  csr_trap_unit #(.XLEN(64), .NUM_LCL_IRQ(NL), .MTVEC_RST(64'h0), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_vld_i(instr_vld_i), .pc_i(pc_i), .csr_op_i(csr_op_i),
    .csr_addr_i(csr_addr_i), .rs1_idx_i(rs1_idx_i), .data_rs1_i(data_rs1_i),
    .csr_imm_i(csr_imm_i), .addr_reg_wr_i(addr_reg_wr_i), .exp_vld_i(exp_vld_i),
    .exp_cause_i(exp_cause_i), .exp_tval_i(exp_tval_i), .mret_i(mret_i), .retire_i(retire_i),
    .ext_irq_i(ext_irq_i), .sft_irq_i(sft_irq_i), .tmr_irq_i(tmr_irq_i), .lcl_irq_i(lcl_irq_i),
    .wb_wen_o(wb_wen_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .busy_o(busy_o), .glb_irq_o(glb_irq_o));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model of architectural state
  bit m_mie, m_mpie;
  logic [63:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mcycle, m_minstret;
  bit m_wr_cyc, m_wr_ins;
  logic [63:0] m_cyc_val, m_ins_val;
  bit drop_irq_in_trap = 0;
  logic [63:0] last_wb, last_redir, pc_ctr = 64'h1000;
  logic last_wen;

  task automatic m_reset();
    m_mie = 0; m_mpie = 0; m_mie_reg = '0; m_mtvec = 64'h0; m_mscratch = '0; m_mepc = '0;
    m_mcause = '0; m_mtval = '0; m_mcycle = '0; m_minstret = '0; m_wr_cyc = 0; m_wr_ins = 0;
  endtask

  function automatic logic [63:0] m_mip();
    logic [63:0] v;
    v = '0;
    v[3] = sft_irq_i; v[7] = tmr_irq_i; v[11] = ext_irq_i;
    for (int k = 0; k < NL; k++) v[16+k] = lcl_irq_i[k];
    return v;
  endfunction

  function automatic int m_irq_code();
    int order[7] = '{11, 3, 7, 16, 17, 18, 19};
    logic [63:0] p;
    p = m_mip() & m_mie_reg;
    for (int k = 0; k < 7; k++) if (p[order[k]]) return order[k];
    return -1;
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a, output bit ok);
    ok = 1;
    case (a)
      12'h300: return (64'(m_mpie) << 7) | (64'(m_mie) << 3);
      12'h304: return m_mie_reg;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip();
      12'hB00: return m_mcycle;
      12'hB02: return m_minstret;
      default: begin ok = 0; return '0; end
    endcase
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [63:0] v);
    case (a)
      12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
      12'h304: m_mie_reg = v & 64'h0000_0000_000F_0888;
      12'h305: m_mtvec = v & ~64'h2;
      12'h340: m_mscratch = v;
      12'h341: m_mepc = v & ~64'h3;
      12'h342: m_mcause = v;
      12'h343: m_mtval = v;
      default: ;
    endcase
  endtask

  task automatic tick();
    retire_i = 1'($urandom_range(0, 1));
    @(posedge clk);
    if (!rst_n) begin
      m_mcycle = '0; m_minstret = '0;
    end else begin
      m_mcycle = m_wr_cyc ? m_cyc_val : m_mcycle + 64'd1;
      if (m_wr_ins) m_minstret = m_ins_val;
      else if (retire_i) m_minstret = m_minstret + 64'd1;
    end
    m_wr_cyc = 0; m_wr_ins = 0;
    #1;
  endtask

  task automatic exec(input logic [63:0] pc, input logic [5:0] op, input logic [11:0] addr,
                      input logic [4:0] rs1, input logic [63:0] rv, input logic [4:0] imm,
                      input logic [4:0] rd, input bit ev, input logic [3:0] ec,
                      input logic [63:0] etv, input bit mr);
    bit ok, is_imm, wr, illegal, is_exc, is_irq, csr_go;
    logic [63:0] old, src, nv, cause, tval, target;
    int code;
    old    = m_read(addr, ok);
    is_imm = (op[5:3] != 0);
    src    = is_imm ? 64'(imm) : rv;
    wr     = (op[0] || op[3]) ? 1'b1 : (is_imm ? (imm != 0) : (rs1 != 0));
    illegal = (op != 0) && (!ok || (wr && addr[11:10] == 2'b11));
    is_exc = ev || illegal;
    code   = m_irq_code();
    is_irq = !is_exc && m_mie && code >= 0;
    csr_go = !is_exc && !is_irq && !mr && op != 0;
    if (op[0] || op[3]) nv = src;
    else if (op[1] || op[4]) nv = old | src;
    else nv = old & ~src;
    if (csr_go && wr && addr == 12'hB00) begin m_wr_cyc = 1; m_cyc_val = nv; end
    if (csr_go && wr && addr == 12'hB02) begin m_wr_ins = 1; m_ins_val = nv; end
    instr_vld_i = 1; pc_i = pc; csr_op_i = op; csr_addr_i = addr; rs1_idx_i = rs1;
    data_rs1_i = rv; csr_imm_i = imm; addr_reg_wr_i = rd; exp_vld_i = ev; exp_cause_i = ec;
    exp_tval_i = etv; mret_i = mr;
    tick();
    instr_vld_i = 0; csr_op_i = '0; exp_vld_i = 0; mret_i = 0;
    if (is_exc || is_irq) begin
      last_wen = wb_wen_o;
      check_val("trap_busy", busy_o, 1);
      check_val("trap_nowb", wb_wen_o, 0);
      check_val("trap_noredir", redirect_o, 0);
      if (drop_irq_in_trap) begin
        ext_irq_i = 0; sft_irq_i = 0; tmr_irq_i = 0; lcl_irq_i = '0;
      end
      cause = is_exc ? (ev ? 64'(ec) : 64'd2) : ((64'd1 << 63) | 64'(code));
      tval  = ev ? etv : 64'd0;
      m_mepc = pc & ~64'h3;
      tick();
      m_mcause = cause; m_mtval = tval; m_mpie = m_mie; m_mie = 0;
      target = (m_mtvec[0] && is_irq) ? (m_mtvec & ~64'h3) + 64'(4 * code) : (m_mtvec & ~64'h3);
      last_redir = redirect_pc_o;
      check_val("redir_pulse", redirect_o, 1);
      check_val("redir_pc", redirect_pc_o, target);
      tick();
      check_val("redir_end", redirect_o, 0);
      check_val("trap_idle", busy_o, 0);
      check_val("trap_mie", glb_irq_o, m_mie);
    end else if (mr) begin
      last_redir = redirect_pc_o;
      check_val("mret_busy", busy_o, 1);
      check_val("mret_redir", redirect_o, 1);
      check_val("mret_pc", redirect_pc_o, m_mepc);
      tick();
      m_mie = m_mpie; m_mpie = 1;
      check_val("mret_idle", busy_o, 0);
      check_val("mret_mie", glb_irq_o, m_mie);
    end else if (op != 0) begin
      last_wb = wb_data_o; last_wen = wb_wen_o;
      check_val("wb_wen", wb_wen_o, rd != 0);
      check_val("wb_addr", wb_addr_o, rd);
      check_val("wb_data", wb_data_o, old);
      check_val("csr_busy", busy_o, 0);
      if (wr) m_write(addr, nv);
      tick();
      check_val("wb_once", wb_wen_o, 0);
    end else begin
      check_val("plain_nowb", wb_wen_o, 0);
      check_val("plain_busy", busy_o, 0);
    end
  endtask

  task automatic csr_do(input logic [5:0] op, input logic [11:0] addr, input logic [4:0] rs1,
                        input logic [63:0] rv, input logic [4:0] imm, input logic [4:0] rd);
    pc_ctr = pc_ctr + 64'd4;
    exec(pc_ctr, op, addr, rs1, rv, imm, rd, 0, 4'd0, '0, 0);
  endtask

  task automatic rd_csr(input logic [11:0] addr);
    csr_do(OP_RS, addr, 5'd0, '0, 5'd0, 5'd1);
  endtask

  logic [11:0] addrs[13] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                             12'h344, 12'hB00, 12'hB02, 12'hC00, 12'h7C0, 12'hF14};

  initial begin
    int sel;
    logic [5:0] op;
    m_reset();
    #2 rst_n = 0;
    repeat (3) tick();
    check_val("rst_wb_wen", wb_wen_o, 0);
    check_val("rst_wb_data", wb_data_o, 0);
    check_val("rst_redirect", redirect_o, 0);
    check_val("rst_redir_pc", redirect_pc_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_glb_irq", glb_irq_o, 0);
    rst_n = 1;
    tick();

    // 1: csrrw swap of mscratch
    csr_do(OP_RW, 12'h340, 5'd6, 64'h1234, 5'd0, 5'd0);
    csr_do(OP_RW, 12'h340, 5'd6, 64'hA5A5, 5'd0, 5'd5);
    check_val("t1_wb_data", last_wb, 64'h1234);
    rd_csr(12'h340);
    check_val("t1_mscratch", last_wb, 64'hA5A5);

    // 2: read-only forms suppress the write
    csr_do(OP_RW, 12'h300, 5'd2, 64'h88, 5'd0, 5'd0);
    csr_do(OP_RS, 12'h300, 5'd0, 64'hFFFF, 5'd0, 5'd0);
    check_val("t2_x0_nowb", last_wen, 0);
    csr_do(OP_RCI, 12'h300, 5'd0, '0, 5'd0, 5'd1);
    check_val("t2_rci_data", last_wb, 64'h88);
    rd_csr(12'h300);
    check_val("t2_mstatus", last_wb, 64'h88);
    csr_do(OP_RW, 12'h300, 5'd2, 64'h0, 5'd0, 5'd0);

    // 3: vectored timer interrupt, then deassert during TRAP
    csr_do(OP_RW, 12'h305, 5'd2, 64'h8001, 5'd0, 5'd0);
    csr_do(OP_RW, 12'h304, 5'd2, 64'h80, 5'd0, 5'd0);
    tmr_irq_i = 1;
    csr_do(OP_RSI, 12'h300, 5'd0, '0, 5'd8, 5'd0);
    exec(64'h200, 6'd0, 12'h0, 5'd0, '0, 5'd0, 5'd0, 0, 4'd0, '0, 0);
    check_val("t3_redir_pc", last_redir, 64'h801C);
    check_val("t3_mie_off", glb_irq_o, 0);
    rd_csr(12'h342);
    check_val("t3_mcause", last_wb, 64'h8000_0000_0000_0007);
    rd_csr(12'h341);
    check_val("t3_mepc", last_wb, 64'h200);
    rd_csr(12'h300);
    check_val("t3_mstatus", last_wb, 64'h80);
    csr_do(OP_RW, 12'h342, 5'd2, 64'h0, 5'd0, 5'd0);
    csr_do(OP_RSI, 12'h300, 5'd0, '0, 5'd8, 5'd0);
    drop_irq_in_trap = 1;
    exec(64'h300, 6'd0, 12'h0, 5'd0, '0, 5'd0, 5'd0, 0, 4'd0, '0, 0);
    drop_irq_in_trap = 0;
    rd_csr(12'h342);
    check_val("t3_drop_cause", last_wb, 64'h8000_0000_0000_0007);

    // 4: interrupt priority, exception beats interrupt
    csr_do(OP_RW, 12'h304, 5'd2, 64'h10808, 5'd0, 5'd0);
    ext_irq_i = 1; sft_irq_i = 1; lcl_irq_i = 4'b0001;
    csr_do(OP_RSI, 12'h300, 5'd0, '0, 5'd8, 5'd0);
    exec(64'h400, 6'd0, 12'h0, 5'd0, '0, 5'd0, 5'd0, 0, 4'd0, '0, 0);
    rd_csr(12'h342);
    check_val("t4_irq_cause", last_wb, 64'h8000_0000_0000_000B);
    csr_do(OP_RSI, 12'h300, 5'd0, '0, 5'd8, 5'd0);
    exec(64'h408, 6'd0, 12'h0, 5'd0, '0, 5'd0, 5'd0, 1, 4'd2, 64'h55, 1);
    rd_csr(12'h342);
    check_val("t4_exc_cause", last_wb, 64'h2);
    rd_csr(12'h343);
    check_val("t4_exc_tval", last_wb, 64'h55);
    ext_irq_i = 0; sft_irq_i = 0; tmr_irq_i = 0; lcl_irq_i = '0;

    // 5: illegal CSR, then mret
    csr_do(OP_RSI, 12'h300, 5'd0, '0, 5'd8, 5'd0);
    exec(64'h404, OP_RW, 12'hC00, 5'd3, 64'h77, 5'd0, 5'd9, 0, 4'd0, '0, 0);
    check_val("t5_nowb", last_wen, 0);
    rd_csr(12'h342);
    check_val("t5_cause", last_wb, 64'h2);
    rd_csr(12'h343);
    check_val("t5_tval", last_wb, 64'h0);
    exec(64'h500, 6'd0, 12'h0, 5'd0, '0, 5'd0, 5'd0, 0, 4'd0, '0, 1);
    check_val("t5_mret_pc", last_redir, 64'h404);
    check_val("t5_mie_back", glb_irq_o, 1);

    // 6: mcycle wrap, reset during TRAP
    csr_do(OP_RW, 12'hB00, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0);
    csr_do(OP_RS, 12'hB00, 5'd0, '0, 5'd0, 5'd2);
    check_val("t6_wrap", last_wb, 64'h0);
    csr_do(OP_RW, 12'h340, 5'd1, 64'hBEEF, 5'd0, 5'd0);
    instr_vld_i = 1; exp_vld_i = 1; exp_cause_i = 4'd5; pc_i = 64'h600;
    tick();
    instr_vld_i = 0; exp_vld_i = 0;
    check_val("t6_in_trap", busy_o, 1);
    rst_n = 0;
    m_reset();
    #1;
    check_val("t6_rst_busy", busy_o, 0);
    check_val("t6_rst_redir", redirect_o, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) rst_n = 1;
      tick();
      check_val("t6_no_pulse", redirect_o, 0);
    end
    rd_csr(12'h340);
    check_val("t6_mscratch_rst", last_wb, 64'h0);
    rd_csr(12'h305);
    check_val("t6_mtvec_rst", last_wb, 64'h0);

    // random instruction stream
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        ext_irq_i = ($urandom_range(0, 3) == 0);
        sft_irq_i = ($urandom_range(0, 3) == 0);
        tmr_irq_i = ($urandom_range(0, 3) == 0);
        lcl_irq_i = 4'($urandom);
      end
      sel = $urandom_range(0, 6);
      op  = (sel == 6) ? 6'd0 : 6'(1 << sel);
      pc_ctr = pc_ctr + 64'd4;
      exec(pc_ctr, op, addrs[$urandom_range(0, 12)], 5'($urandom_range(0, 3)),
           {32'($urandom), 32'($urandom)}, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
           5'($urandom), ($urandom_range(0, 9) == 0), 4'($urandom),
           {32'($urandom), 32'($urandom)}, ($urandom_range(0, 9) == 0));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
